arb16_rr_ctrl: RTL

ARB16_RR_CTRL -- requirements
Module: arb16_rr_ctrl

---
 rtl/arb16_pkg.sv | 20 ++
 rtl/arb16_rr_pick.sv | 27 ++
 rtl/arb16_rr_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/arb16_pkg.sv
// Shared sizes, FSM state type and a one-hot helper for the 16-way round-robin arbiter.
// Imported by arb16_rr_pick and arb16_rr_ctrl.
package arb16_pkg;

  localparam int N_REQ = 16;
  localparam int ID_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/arb16_rr_pick.sv
// Rotated-priority search: first set req bit at or above ptr, wrapping 15->0.
// Purely combinational; any=0 means win_id carries no meaning.
module arb16_rr_pick
  import arb16_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  win_id,
  output logic             any
);

  logic [ID_W-1:0] cand;

  // Walk offsets from the far end down so the smallest offset from ptr lands last.
  always_comb begin
    win_id = ptr;
    cand   = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + ID_W'(i);
      if (req[cand]) begin
        win_id = cand;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/arb16_rr_ctrl.sv
// 16-requester round-robin grant FSM: grant 1 cycle after request, held until done or req drop.
// Optional forced release after TIMEOUT_CYCLES grant cycles when ARB16_TIMEOUT_EN is defined.
module arb16_rr_ctrl
  import arb16_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("arb16_rr_ctrl: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t           state_q;
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  ptr_d;
  logic [N_REQ-1:0] gnt_q;
  logic [ID_W-1:0]  gnt_id_q;
  logic             gnt_valid_q;

  logic [ID_W-1:0]  win_id;
  logic             win_any;
  logic             rel_normal;

  arb16_rr_pick u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .win_id (win_id),
    .any    (win_any)
  );

  // Releasing holder hands priority to its upper neighbour; 4-bit add wraps 15->0.
  assign ptr_d      = gnt_id_q + ID_W'(1);
  assign rel_normal = done || !req[gnt_id_q];

`ifdef ARB16_TIMEOUT_EN
  localparam logic [15:0] HOLD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] hold_cnt_q;
  logic        timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          timeout_q <= 1'b0;
          if (win_any) begin
            state_q     <= GRANT;
            gnt_q       <= onehot(win_id);
            gnt_id_q    <= win_id;
            gnt_valid_q <= 1'b1;
            hold_cnt_q  <= '0;
          end
        end
        GRANT: begin
          // A normal release in the limit cycle takes precedence and suppresses the pulse.
          if (rel_normal || (hold_cnt_q == HOLD_LAST)) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= ptr_d;
            timeout_q   <= !rel_normal;
          end else begin
            hold_cnt_q <= hold_cnt_q + 16'd1;
            timeout_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          gnt_q       <= '0;
          gnt_valid_q <= 1'b0;
          timeout_q   <= 1'b0;
        end
      endcase
    end
  end

  assign timeout = timeout_q;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_any) begin
            state_q     <= GRANT;
            gnt_q       <= onehot(win_id);
            gnt_id_q    <= win_id;
            gnt_valid_q <= 1'b1;
          end
        end
        GRANT: begin
          if (rel_normal) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= ptr_d;
          end
        end
        default: begin
          state_q     <= IDLE;
          gnt_q       <= '0;
          gnt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign timeout = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;

endmodule
